// File: rtl/alu_pkg.sv
// Shared types for the 16-bit ALU result stage: opcode encoding, flag bundle
// and the default datapath width.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NAND = 4'd5,
    OP_NOR  = 4'd6,
    OP_XNOR = 4'd7,
    OP_NOT  = 4'd8,
    OP_SHL1 = 4'd9,
    OP_SHR1 = 4'd10,
    OP_ASR1 = 4'd11,
    OP_INC  = 4'd12,
    OP_DEC  = 4'd13,
    OP_PASSA = 4'd14,
    OP_PASSB = 4'd15
  } aluOp_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } aluFlags_t;

endpackage

// File: rtl/alu_func_unit.sv
// Combinational ALU core: selects one of 16 function results and derives the
// carry/borrow and signed-overflow flags. Arithmetic is WIDTH+1 bits wide so
// the carry/borrow falls out as the top bit.
module alu_func_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  aluOp_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] notA;
  logic [WIDTH-1:0] arithB;
  logic [WIDTH:0]   sumW;
  logic [WIDTH:0]   diffW;

  alu_not #(.WIDTH(WIDTH)) uNot (
    .a(a),
    .y(notA)
  );

  // INC/DEC reuse the adder/subtractor with a constant one as second operand.
  assign arithB = (op == OP_INC || op == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign sumW   = {1'b0, a} + {1'b0, arithB};
  assign diffW  = {1'b0, a} - {1'b0, arithB};

  // Function select with flag generation.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can
    // leave a value unassigned and infer a latch.
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      OP_ADD, OP_INC: begin
        result = sumW[WIDTH-1:0];
        carry  = sumW[WIDTH];
        ovf    = (a[MSB] == arithB[MSB]) && (sumW[MSB] != a[MSB]);
      end
      OP_SUB, OP_DEC: begin
        result = diffW[WIDTH-1:0];
        carry  = diffW[WIDTH];  // borrow: the extension bit goes high when a < subtrahend
        ovf    = (a[MSB] != arithB[MSB]) && (diffW[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_NOT:  result = notA;
      OP_SHL1: begin
        result = {a[MSB-1:0], 1'b0};
        carry  = a[MSB];
      end
      OP_SHR1: begin
        result = {1'b0, a[MSB:1]};
        carry  = a[0];
      end
      OP_ASR1: begin
        result = {a[MSB], a[MSB:1]};
        carry  = a[0];
      end
      OP_PASSA: result = a;
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_not.sv
// Bitwise-NOT operand network feeding mux input 8 of the function unit.
module alu_not #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a;

endmodule

// File: rtl/alu_result_stage.sv
// Two-stage pipelined ALU result stage. S1 captures opcode/operands, S2
// captures the computed result and flags. Both stages use a valid bit and the
// "load when empty or draining" rule, giving full throughput and full
// backpressure with no bubbles.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [3:0]       out_op,
  output logic [15:0]      done_count
);

  logic             s1Valid;
  aluOp_t           s1Op;
  logic [WIDTH-1:0] s1A;
  logic [WIDTH-1:0] s1B;

  logic             s2Valid;
  aluOp_t           s2Op;
  logic [WIDTH-1:0] s2Result;
  aluFlags_t        s2Flags;

  logic [15:0]      doneCount;

  logic             s2Free;
  logic             inFire;
  logic             s1Advance;
  logic             outFire;

  logic [WIDTH-1:0] fuResult;
  logic             fuCarry;
  logic             fuOvf;
  aluFlags_t        fuFlags;

  // S2 can take new data when it is empty or its beat leaves this cycle;
  // S1 can then accept whenever it is empty or moving into S2.
  assign s2Free    = !s2Valid || out_ready;
  assign in_ready  = !s1Valid || s2Free;
  assign inFire    = in_valid && in_ready;
  assign s1Advance = s1Valid && s2Free;
  assign outFire   = s2Valid && out_ready;

  alu_func_unit #(.WIDTH(WIDTH)) uFunc (
    .op    (s1Op),
    .a     (s1A),
    .b     (s1B),
    .result(fuResult),
    .carry (fuCarry),
    .ovf   (fuOvf)
  );

  // Zero is taken from the exact WIDTH-bit value that S2 will hold.
  assign fuFlags = '{zero: (fuResult == '0), carry: fuCarry, ovf: fuOvf};

  // S1: operand/opcode capture on an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      s1Valid <= 1'b0;
      s1Op    <= OP_ADD;
      s1A     <= '0;
      s1B     <= '0;
    end else begin
      if (in_ready) s1Valid <= in_valid;
      if (inFire) begin
        s1Op <= aluOp_t'(in_op);
        s1A  <= in_a;
        s1B  <= in_b;
      end
    end
  end

  // S2: result/flag capture when S1 advances; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid  <= 1'b0;
      s2Op     <= OP_ADD;
      s2Result <= '0;
      s2Flags  <= '0;
    end else begin
      if (s2Free) s2Valid <= s1Valid;
      if (s1Advance) begin
        s2Op     <= s1Op;
        s2Result <= fuResult;
        s2Flags  <= fuFlags;
      end
    end
  end

  // Delivered-result counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doneCount <= '0;
    end else if (outFire) begin
      doneCount <= doneCount + 16'd1;
    end
  end

  assign out_valid  = s2Valid;
  assign out_result = s2Result;
  assign out_zero   = s2Flags.zero;
  assign out_carry  = s2Flags.carry;
  assign out_ovf    = s2Flags.ovf;
  assign out_op     = s2Op;
  assign done_count = doneCount;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed steps plus a scoreboard
// that predicts each accepted beat and compares it when it is delivered.
`timescale 1ns/1ps
module tb_alu_result_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] result;
    logic        zero;
    logic        carry;
    logic        ovf;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_carry;
  logic        out_ovf;
  logic [3:0]  out_op;
  logic [15:0] done_count;

  int    errors = 0;
  int    checks = 0;
  beat_t sb[$];
  logic [15:0] expCount = '0;

  alu_result_stage #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_zero  (out_zero),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_op    (out_op),
    .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Independent reference model of one beat.
  function automatic beat_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    beat_t r;
    r = '0;
    r.op = op;
    case (op)
      4'd0: begin
        r.result = a + b;
        r.carry  = (int'(a) + int'(b)) > 65535;
        r.ovf    = (a[15] == b[15]) && (r.result[15] != a[15]);
      end
      4'd1: begin
        r.result = a - b;
        r.carry  = a < b;
        r.ovf    = (a[15] != b[15]) && (r.result[15] != a[15]);
      end
      4'd2:  r.result = a & b;
      4'd3:  r.result = a | b;
      4'd4:  r.result = a ^ b;
      4'd5:  r.result = ~(a & b);
      4'd6:  r.result = ~(a | b);
      4'd7:  r.result = ~(a ^ b);
      4'd8:  r.result = ~a;
      4'd9:  begin r.result = a << 1; r.carry = a[15]; end
      4'd10: begin r.result = a >> 1; r.carry = a[0]; end
      4'd11: begin r.result = $unsigned($signed(a) >>> 1); r.carry = a[0]; end
      4'd12: begin r.result = a + 16'd1; r.carry = (a == 16'hFFFF); r.ovf = (a == 16'h7FFF); end
      4'd13: begin r.result = a - 16'd1; r.carry = (a == 16'h0000); r.ovf = (a == 16'h8000); end
      4'd14: r.result = a;
      default: r.result = b;
    endcase
    r.zero = (r.result == 16'h0000);
    return r;
  endfunction

  // Monitor: counter check every cycle, pop/compare on output transfer,
  // push prediction on input transfer.
  always @(negedge clk) begin
    beat_t expBeat;
    if (!rst_n) begin
      sb.delete();
      expCount = '0;
    end else begin
      check("done_count", done_count, expCount);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", out_valid, 0);
        end else begin
          expBeat = sb.pop_front();
          check("beat", {out_op, out_result, out_zero, out_carry, out_ovf}, expBeat);
        end
        expCount = expCount + 16'd1;
      end
      if (in_valid && in_ready) sb.push_back(model(in_op, in_a, in_b));
    end
  end

  task automatic sendBeat(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (waitCycles >= 100) check("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for a beat, check it against constants, let it transfer.
  task automatic expectOut(input string tag, input logic [15:0] res, input logic z,
                           input logic c, input logic v);
    int waitCycles = 0;
    while (!out_valid && waitCycles < 2) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, out_result, res);
    check({tag, "_flags"}, {out_zero, out_carry, out_ovf}, {z, c, v});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {out_result, out_zero, out_carry, out_ovf, out_op}, 0);
    check("rst_done_count", done_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // Directed function checks.
    sendBeat(4'd0, 16'hFFFF, 16'h0001);
    check("add_not_early", out_valid, 0);
    expectOut("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    check("add_done_count", done_count, 16'd1);
    sendBeat(4'd1, 16'h8000, 16'h0001);
    expectOut("sub_ovf", 16'h7FFF, 1'b0, 1'b0, 1'b1);
    sendBeat(4'd1, 16'h0001, 16'h0002);
    expectOut("sub_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    sendBeat(4'd8, 16'h00F0, 16'h1234);
    expectOut("not_a", 16'hFF0F, 1'b0, 1'b0, 1'b0);
    sendBeat(4'd11, 16'h8001, 16'h0000);
    expectOut("asr1", 16'hC000, 1'b0, 1'b1, 1'b0);
    sendBeat(4'd12, 16'h7FFF, 16'h0000);
    expectOut("inc_ovf", 16'h8000, 1'b0, 1'b0, 1'b1);
    sendBeat(4'd13, 16'h0000, 16'h0000);
    expectOut("dec_borrow", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    sendBeat(4'd9, 16'h8001, 16'h0000);
    expectOut("shl1", 16'h0002, 1'b0, 1'b1, 1'b0);
    drain();

    // Random beats over all opcodes, checked by the scoreboard.
    for (int i = 0; i < 48; i++) begin
      sendBeat(4'(i % 16), 16'($urandom), 16'($urandom));
    end
    drain();

    // Back-to-back stream: 8 results on 8 consecutive cycles.
    fork
      begin
        for (int i = 0; i < 8; i++) sendBeat(4'd14, 16'h0100 + 16'(i), 16'h0000);
      end
      begin
        int w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
          @(negedge clk);
          w++;
        end
        if (w >= 10) check("stream_start_timeout", out_valid, 1);
        for (int i = 0; i < 8; i++) begin
          check("stream_gapless", out_valid, 1);
          if (i < 7) @(negedge clk);
        end
      end
    join
    drain();

    // Stall for 5 cycles in the middle of a stream.
    fork
      begin
        for (int i = 0; i < 10; i++) sendBeat(4'd15, 16'h0000, 16'hA000 + 16'(i));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_result;
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_hold_result", out_result, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight.
    sendBeat(4'd14, 16'h1111, 16'h0000);
    sendBeat(4'd14, 16'h2222, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {out_result, out_zero, out_carry, out_ovf, out_op}, 0);
    check("midrst_done_count", done_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_stale", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
    end
    @(posedge clk);
    #1;

    // done_count wrap: 65535 transfers, then one more.
    for (int i = 0; i < 65535; i++) sendBeat(4'd15, 16'h0000, 16'(i));
    drain();
    check("count_ffff", done_count, 16'hFFFF);
    sendBeat(4'd0, 16'h0003, 16'h0004);
    drain();
    check("count_wrap", done_count, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
